// File: rtl/imem_arbiter.sv
// imem_arbiter: arbitrates a CPU instruction fetch port and a program-loader write port onto
// one shared single-port instruction memory.
//
// Fetches win ties. A starve counter bounds how many fetches can be granted while a load is
// kept waiting. Every output is registered.
//
// Optional feature: define IMEM_ADDR_CHECK_EN to reject requests whose address is not word
// aligned or whose last byte falls outside MEM_BYTES. A rejected request gets its grant and an
// err pulse, but no memory access. Without the macro, address bits [1:0] are ignored and err
// is tied low.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   fetch_req/fetch_addr            fetch request and byte address
//   fetch_gnt                       one-cycle fetch accept pulse
//   fetch_valid/fetch_data          one-cycle pulse one cycle after fetch_gnt, held data word
//   load_req/load_addr/load_data    loader write request, byte address and word
//   load_gnt                        one-cycle pulse in the cycle the write is issued
//   mem_addr/mem_we/mem_wdata       memory address (word aligned), write strobe, write word
//   mem_rdata                       memory read word for the address presented this cycle
//   err                             one-cycle pulse on a rejected request
module imem_arbiter #(
    parameter int unsigned MEM_BYTES    = 1024,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    input  logic        load_req,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StFetchWait,
        StLoad
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] starve_q;

    logic arb_en;
    logic pick_fetch;
    logic pick_load;
    logic fetch_bad;
    logic load_bad;

`ifdef IMEM_ADDR_CHECK_EN
    // The range check is done in 33 bits so that an address near 2^32 cannot wrap into range.
    function automatic logic addr_bad(input logic [31:0] a);
        logic [32:0] last_byte;
        last_byte = {1'b0, a} + 33'd3;
        return (a[1:0] != 2'b00) || (last_byte >= 33'(MEM_BYTES));
    endfunction

    assign fetch_bad = addr_bad(fetch_addr);
    assign load_bad  = addr_bad(load_addr);
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{fetch_addr[1:0], load_addr[1:0]};
    assign fetch_bad        = 1'b0;
    assign load_bad         = 1'b0;
    assign err              = 1'b0;
`endif

    // A rejected request leaves the FSM in IDLE while its grant is still high. Holding off
    // arbitration for that cycle keeps the requester from being granted a second time before
    // it has seen the first grant.
    assign arb_en = (state_q == StIdle) && !fetch_gnt && !load_gnt;

    always_comb begin
        pick_fetch = 1'b0;
        pick_load  = 1'b0;
        if (arb_en) begin
            if (fetch_req && load_req) begin
                if (starve_q == CntMax) begin
                    pick_load = 1'b1;
                end else begin
                    pick_fetch = 1'b1;
                end
            end else begin
                pick_fetch = fetch_req;
                pick_load  = load_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            fetch_gnt   <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            load_gnt    <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
`ifdef IMEM_ADDR_CHECK_EN
            err         <= 1'b0;
`endif
        end else begin
            fetch_gnt   <= 1'b0;
            fetch_valid <= 1'b0;
            load_gnt    <= 1'b0;
            mem_we      <= 1'b0;
`ifdef IMEM_ADDR_CHECK_EN
            err         <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (pick_fetch) begin
                        fetch_gnt <= 1'b1;
                        if (load_req && (starve_q != CntMax)) begin
                            starve_q <= starve_q + 1'b1;
                        end
                        if (fetch_bad) begin
`ifdef IMEM_ADDR_CHECK_EN
                            err <= 1'b1;
`endif
                        end else begin
                            mem_addr <= {fetch_addr[31:2], 2'b00};
                            state_q  <= StFetchWait;
                        end
                    end else if (pick_load) begin
                        load_gnt <= 1'b1;
                        starve_q <= '0;
                        if (load_bad) begin
`ifdef IMEM_ADDR_CHECK_EN
                            err <= 1'b1;
`endif
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {load_addr[31:2], 2'b00};
                            mem_wdata <= load_data;
                            state_q   <= StLoad;
                        end
                    end
                end
                StFetchWait: begin
                    // mem_rdata belongs to the address presented during this cycle.
                    fetch_data  <= mem_rdata;
                    fetch_valid <= 1'b1;
                    state_q     <= StIdle;
                end
                StLoad: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed vector table, hand-written starvation and reset
// sequences, then random traffic checked against a transaction-level model of the arbiter.
module tb_imem_arbiter;

    localparam int unsigned LIMIT = 4;
`ifdef IMEM_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        load_req;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        err;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_word = 32'h0;
    logic [31:0] ref_mem [256];
    logic [31:0] mem [256];

    imem_arbiter #(
        .MEM_BYTES   (1024),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_gnt  (fetch_gnt),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .load_req   (load_req),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_gnt   (load_gnt),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] preload(input int i);
        case (i)
            1:       return 32'h11112222;
            2:       return 32'h8C010004;
            255:     return 32'h0BADF00D;
            default: return {8'(i), 8'(~i), 8'(i * 3), 8'h5A};
        endcase
    endfunction

    // Memory: read data follows the presented address; write lands on the clock edge; contents
    // are restored to the preload image on every clock edge seen with reset asserted.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= preload(i);
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = preload(i);
        last_word = 32'h0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " fetch_gnt"}, 32'(fetch_gnt), 0);
        chk({tag, " fetch_valid"}, 32'(fetch_valid), 0);
        chk({tag, " fetch_data"}, fetch_data, 0);
        chk({tag, " load_gnt"}, 32'(load_gnt), 0);
        chk({tag, " mem_we"}, 32'(mem_we), 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " err"}, 32'(err), 0);
    endtask

    task automatic apply_reset();
        fetch_req = 1'b0;
        load_req  = 1'b0;
        rst_n     = 1'b0;
        ref_init();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_maddr,
                            input logic [31:0] exp_word, input bit rej);
        int n = 0;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!fetch_gnt && n < 8);
        fetch_req = 1'b0;
        chk("fetch gnt latency", 32'(n), 1);
        chk("fetch mem_we", 32'(mem_we), 0);
        chk("fetch err", 32'(err), 32'(rej));
        if (!rej) chk("fetch mem_addr", mem_addr, exp_maddr);
        @(posedge clk);
        #1;
        chk("fetch valid", 32'(fetch_valid), 32'(!rej));
        chk("fetch gnt pulse", 32'(fetch_gnt), 0);
        if (!rej) last_word = exp_word;
        chk("fetch data", fetch_data, last_word);
        @(posedge clk);
        #1;
        chk("fetch valid pulse", 32'(fetch_valid), 0);
        chk("fetch data hold", fetch_data, last_word);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_maddr, input bit rej);
        int n = 0;
        load_req  = 1'b1;
        load_addr = addr;
        load_data = data;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!load_gnt && n < 8);
        load_req = 1'b0;
        chk("load gnt latency", 32'(n), 1);
        chk("load err", 32'(err), 32'(rej));
        chk("load no fetch_gnt", 32'(fetch_gnt), 0);
        chk("load mem_we", 32'(mem_we), 32'(!rej));
        if (!rej) begin
            chk("load mem_addr", mem_addr, exp_maddr);
            chk("load mem_wdata", mem_wdata, data);
            ref_mem[exp_maddr[9:2]] = data;
        end
        @(posedge clk);
        #1;
        chk("load mem_we pulse", 32'(mem_we), 0);
        chk("load gnt pulse", 32'(load_gnt), 0);
    endtask

    // Both requesters held high: grants must run F,F,F,F,L repeatedly, one every 2 cycles.
    task automatic starve_seq();
        int k = 0;
        int cyc = 0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h20;
        load_req   = 1'b1;
        load_addr  = 32'h30;
        load_data  = 32'hCAFE0001;
        while (k < 15 && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
            if (fetch_gnt || load_gnt) begin
                chk("starve single grant", 32'(fetch_gnt & load_gnt), 0);
                chk("starve pattern load_gnt", 32'(load_gnt), 32'((k % 5) == 4));
                k++;
            end
        end
        fetch_req = 1'b0;
        load_req  = 1'b0;
        chk("starve grant count", 32'(k), 15);
        chk("starve grant spacing", 32'(cyc), 29);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_in_fetch_wait();
        fetch_req  = 1'b1;
        fetch_addr = 32'h8;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        chk("pre-reset fetch_gnt", 32'(fetch_gnt), 1);
        #2;
        rst_n = 1'b0;
        ref_init();
        #1;
        check_all_zero("async reset");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("post-reset fetch_valid", 32'(fetch_valid), 0);
        end
    endtask

    // Model: the arbiter is free two cycles after any grant; when free it grants whichever
    // request is pending, fetch on a tie unless LIMIT fetches were granted over a waiting load.
    task automatic random_phase();
        int starve = 0;
        int last_gnt = -10;
        bit exp_f;
        bit exp_l;
        bit pend_valid = 1'b0;
        bit fp = 1'b0;
        bit lp = 1'b0;
        logic [31:0] pend_word = 32'h0;
        fetch_req = 1'b0;
        load_req  = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            @(posedge clk);
            #1;
            exp_f = 1'b0;
            exp_l = 1'b0;
            if (c - last_gnt >= 2) begin
                if (fp && lp) begin
                    exp_l = (starve == int'(LIMIT));
                    exp_f = !exp_l;
                end else begin
                    exp_f = fp;
                    exp_l = lp;
                end
            end
            chk("rnd fetch_gnt", 32'(fetch_gnt), 32'(exp_f));
            chk("rnd load_gnt", 32'(load_gnt), 32'(exp_l));
            chk("rnd mem_we", 32'(mem_we), 32'(exp_l));
            chk("rnd fetch_valid", 32'(fetch_valid), 32'(pend_valid));
            if (pend_valid) last_word = pend_word;
            chk("rnd fetch_data", fetch_data, last_word);
            chk("rnd err", 32'(err), 0);
            pend_valid = exp_f;
            if (exp_f) begin
                chk("rnd fetch mem_addr", mem_addr, {fetch_addr[31:2], 2'b00});
                pend_word = ref_mem[fetch_addr[9:2]];
                if (lp && starve < int'(LIMIT)) starve++;
                last_gnt = c;
                fp = 1'b0;
            end
            if (exp_l) begin
                chk("rnd load mem_addr", mem_addr, {load_addr[31:2], 2'b00});
                chk("rnd load mem_wdata", mem_wdata, load_data);
                ref_mem[load_addr[9:2]] = load_data;
                starve = 0;
                last_gnt = c;
                lp = 1'b0;
            end
            if (fp && $urandom_range(9, 0) == 0) begin
                fp = 1'b0;
            end else if (!fp && $urandom_range(1, 0) == 1) begin
                fp = 1'b1;
                fetch_addr = CHECK_EN ? {22'h0, 8'($urandom_range(255, 0)), 2'b00}
                                      : 32'($urandom_range(1023, 0));
            end
            if (lp && $urandom_range(9, 0) == 0) begin
                lp = 1'b0;
            end else if (!lp && $urandom_range(2, 0) == 0) begin
                lp = 1'b1;
                load_addr = CHECK_EN ? {22'h0, 8'($urandom_range(255, 0)), 2'b00}
                                     : 32'($urandom_range(1023, 0));
                load_data = $urandom;
            end
            fetch_req = fp;
            load_req  = lp;
        end
        fetch_req = 1'b0;
        load_req  = 1'b0;
    endtask

    typedef struct {
        bit          is_load;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_maddr;
        logic [31:0] exp_word;
        bit          rej;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b1, 32'h010, 32'hDEADBEEF, 32'h010, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h010, 32'h0, 32'h010, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 32'h008, 32'h0, 32'h008, 32'h8C010004, 1'b0};
        vecs[3] = '{1'b0, 32'h006, 32'h0, 32'h004, 32'h11112222, CHECK_EN};
        vecs[4] = '{1'b1, 32'h3FF, 32'h12345678, 32'h3FC, 32'h0, CHECK_EN};
        vecs[5] = '{1'b0, 32'h3FC, 32'h0, 32'h3FC,
                    CHECK_EN ? 32'h0BADF00D : 32'h12345678, 1'b0};
        vecs[6] = '{1'b0, 32'h3FE, 32'h0, 32'h3FC, 32'h12345678, CHECK_EN};
        vecs[7] = '{1'b1, 32'h000, 32'hA5A5A5A5, 32'h000, 32'h0, 1'b0};
        vecs[8] = '{1'b0, 32'h002, 32'h0, 32'h000, 32'hA5A5A5A5, CHECK_EN};
        vecs[9] = '{1'b0, 32'h400, 32'h0, 32'h400, 32'hA5A5A5A5, CHECK_EN};

        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        load_req   = 1'b0;
        load_addr  = 32'h0;
        load_data  = 32'h0;
        rst_n      = 1'b0;
        ref_init();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_load) begin
                do_load(vecs[i].addr, vecs[i].data, vecs[i].exp_maddr, vecs[i].rej);
            end else begin
                do_fetch(vecs[i].addr, vecs[i].exp_maddr, vecs[i].exp_word, vecs[i].rej);
            end
        end

        apply_reset();
        starve_seq();

        do_fetch(32'h8, 32'h8, 32'h8C010004, 1'b0);
        reset_in_fetch_wait();

        apply_reset();
        random_phase();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
